// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared constants and helpers for the register write arbiter
package reg_write_arbiter_pkg;

    localparam int DW_DEF    = 32;
    localparam int NREQ_DEF  = 4;
    localparam int NREGS_DEF = 4;
    localparam int AW_DEF    = 2;
    localparam int NREQ_MAX  = 8;

    // One-hot encode a requester index; callers truncate to their NREQ width.
    function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] idx);
        logic [NREQ_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin winner select
module reg_write_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int cand;

    // Scan upward from ptr with wrap; the first eligible requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!valid && eligible[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register bank with a round-robin shared write port
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                 Clock,
    input  logic                 ClearN,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
    input  logic                 clr_all,
    output logic [NREQ-1:0]      gnt,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [DW-1:0]   regs [NREGS];
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt_nxt;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // A requester still showing its grant has just written and sits this cycle out.
    assign eligible = req & ~gnt;

    reg_write_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .valid    (win_valid),
        .idx      (win_idx)
    );

    // Route the winner's address/data and compute the post-grant pointer and grant.
    always_comb begin
        sel_addr = wr_addr[int'(win_idx)*AW +: AW];
        sel_data = wr_data[int'(win_idx)*DW +: DW];
        gnt_nxt  = NREQ'(onehot(3'(win_idx)));
        ptr_nxt  = (int'(win_idx) == NREQ-1) ? '0 : win_idx + IW'(1);
    end

    // Grant, busy and round-robin pointer; clear outranks any write.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            gnt  <= '0;
            busy <= 1'b0;
            ptr  <= '0;
        end else if (clr_all) begin
            gnt  <= '0;
            busy <= 1'b1;
        end else if (win_valid) begin
            gnt  <= gnt_nxt;
            busy <= 1'b1;
            ptr  <= ptr_nxt;
        end else begin
            gnt  <= '0;
            busy <= 1'b0;
        end
    end

    // Register bank: cleared by reset or clr_all, otherwise written by the winner.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_all) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (win_valid) begin
            regs[sel_addr] <= sel_data;
        end
    end

    assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int NREGS = 4;
    localparam int AW    = 2;
    localparam int DW    = 32;

    logic                Clock = 1'b0;
    logic                ClearN = 1'b0;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  wr_addr;
    logic [NREQ*DW-1:0]  wr_data;
    logic                clr_all;
    logic [NREQ-1:0]     gnt;
    logic [AW-1:0]       rd_addr;
    logic [DW-1:0]       rd_data;
    logic                busy;

    int n_chk  = 0;
    int n_pass = 0;

    reg_write_arbiter #(
        .NREQ  (NREQ),
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .Clock   (Clock),
        .ClearN  (ClearN),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr_all (clr_all),
        .gnt     (gnt),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Winner = eligible requester with the smallest forward distance from ptr.
    function automatic int rr_winner(input logic [NREQ-1:0] elig, input int ptr);
        int w;
        int bestd;
        w = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (elig[i] && ((i - ptr + NREQ) % NREQ) < bestd) begin
                bestd = (i - ptr + NREQ) % NREQ;
                w = i;
            end
        end
        return w;
    endfunction

    logic [DW-1:0]   m_regs [NREGS];
    logic [NREQ-1:0] m_gnt;
    logic            m_busy;
    int              m_ptr;

    // Reference model of the bank and arbiter.
    always @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
            m_gnt  <= '0;
            m_busy <= 1'b0;
            m_ptr  <= 0;
        end else if (clr_all) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
            m_gnt  <= '0;
            m_busy <= 1'b1;
        end else if (rr_winner(req & ~m_gnt, m_ptr) < 0) begin
            m_gnt  <= '0;
            m_busy <= 1'b0;
        end else begin
            m_regs[wr_addr[rr_winner(req & ~m_gnt, m_ptr)*AW +: AW]]
                <= wr_data[rr_winner(req & ~m_gnt, m_ptr)*DW +: DW];
            m_gnt  <= NREQ'(1) << rr_winner(req & ~m_gnt, m_ptr);
            m_ptr  <= (rr_winner(req & ~m_gnt, m_ptr) + 1) % NREQ;
            m_busy <= 1'b1;
        end
    end

    // Every cycle: outputs must track the model.
    always @(negedge Clock) begin
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rd_data", rd_data, m_regs[rd_addr]);
    end

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic look(input int a);
        rd_addr = AW'(a);
        #1;
    endtask

    task automatic set_wr(input int i, input int a, input logic [31:0] d);
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*DW +: DW] = d;
    endtask

    initial begin
        req = '0; wr_addr = '0; wr_data = '0; clr_all = 1'b0; rd_addr = '0;
        repeat (2) step();
        ClearN = 1'b1;
        step();

        // Full contention, each requester writes its index to its own address.
        req = '1;
        for (int i = 0; i < NREQ; i++) set_wr(i, i, 32'(i));
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("contend_gnt", 32'(gnt), 32'(1) << ((k - 1) % 4));
            if (k >= 5) begin
                look(k - 5);
                chk("contend_reg", rd_data, 32'(k - 5));
            end
        end

        // Reset mid-run with all requesting.
        step();
        ClearN = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        for (int a = 0; a < NREGS; a++) begin
            step();
            look(a);
            chk("rst_rd", rd_data, 32'h0);
        end
        ClearN = 1'b1;
        step();
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();

        // Single requester.
        req = 4'b0100;
        set_wr(2, 3, 32'hAFAFAFAF);
        step();
        chk("single_gnt", 32'(gnt), 32'h4);
        look(3);
        chk("single_rd", rd_data, 32'hAFAFAFAF);
        req = '0;
        step();
        chk("single_drop", 32'(gnt), 32'h0);

        // Requester ignoring gnt: grants alternate, writes only on grant edges.
        req = 4'b0001;
        set_wr(0, 0, 32'hA1); step(); chk("hold_g1", 32'(gnt), 32'h1);
        look(0); chk("hold_rd1", rd_data, 32'hA1);
        set_wr(0, 0, 32'hB2); step(); chk("hold_g2", 32'(gnt), 32'h0);
        look(0); chk("hold_rd2", rd_data, 32'hA1);
        set_wr(0, 0, 32'hC3); step(); chk("hold_g3", 32'(gnt), 32'h1);
        set_wr(0, 0, 32'hD4); step(); chk("hold_g4", 32'(gnt), 32'h0);
        look(0); chk("hold_rd4", rd_data, 32'hC3);
        req = '0;

        // Clear priority over a pending request.
        req = '1;
        for (int i = 0; i < NREQ; i++) set_wr(i, i, 32'h12345678);
        repeat (4) step();
        req = '0;
        step();
        look(1); chk("preload", rd_data, 32'h12345678);
        req = 4'b0010;
        set_wr(1, 2, 32'hCAFE0001);
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
        chk("clr_gnt", 32'(gnt), 32'h0);
        chk("clr_busy", 32'(busy), 32'h1);
        look(0); chk("clr_rd0", rd_data, 32'h0);
        look(2); chk("clr_rd2", rd_data, 32'h0);
        step();
        chk("clr_after_gnt", 32'(gnt), 32'h2);
        look(2); chk("clr_after_rd", rd_data, 32'hCAFE0001);
        req = '0;
        step();

        // Collision on address 1 with ptr brought back to 0.
        req = 4'b1000;
        step();
        req = '0;
        step();
        req = 4'b0011;
        set_wr(0, 1, 32'h11111111);
        set_wr(1, 1, 32'h22222222);
        step(); chk("coll_g1", 32'(gnt), 32'h1);
        look(1); chk("coll_rd1", rd_data, 32'h11111111);
        step(); chk("coll_g2", 32'(gnt), 32'h2);
        look(1); chk("coll_rd2", rd_data, 32'h22222222);
        req = '0;
        step();
        look(1); chk("coll_final", rd_data, 32'h22222222);

        // Randomized traffic with occasional clears and asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_wr(i, int'($urandom_range(NREGS - 1)), $urandom);
            clr_all = ($urandom_range(15) == 0);
            rd_addr = AW'($urandom);
            if (!ClearN) ClearN = 1'b1;
            else if ($urandom_range(149) == 0) ClearN = 1'b0;
        end
        ClearN = 1'b1;
        clr_all = 1'b0;
        req = '0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Owns a small bank of 32-bit registers and shares its single write port between NREQ requesters.
- Round-robin arbitration with a registered one-hot grant that doubles as the write acknowledge.
- Adds a synchronous bank-clear command with top priority and one combinational read port.
- Sits between producer blocks and the storage built from the team's DFF-based 32-bit register.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NREGS, 4, number of 32-bit registers in the bank (power of two).
- AW, 2, register address width, log2(NREGS).
- DW, 32, data width.

Ports:
- Clock  in  1  rising-edge clock.
- ClearN  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester write request, level, held until granted.
- wr_addr  in  NREQ*AW  packed register address per requester; requester i uses slice [i*AW +: AW].
- wr_data  in  NREQ*DW  packed write data per requester; slice [i*DW +: DW].
- clr_all  in  1  synchronous clear of the whole bank (single-cycle pulse).
- gnt  out  NREQ  registered one-hot grant; high for exactly one cycle after that requester's write.
- rd_addr  in  AW  read address.
- rd_data  out  DW  combinational read: regs[rd_addr].
- busy  out  1  registered; high in any cycle where gnt is non-zero or a clear was just performed.

Behaviour:
- Reset (ClearN low, asynchronous): all registers 0, gnt 0, busy 0, round-robin pointer 0. Release takes effect at the next rising edge.
- Eligibility: eligible = req & ~gnt. A requester granted in cycle k cannot win again in cycle k, so a requester dropping req on seeing gnt never writes twice.
- Winner: first eligible index searching upward from ptr, wrapping NREQ-1 -> 0.
- Write edge, no clr_all, eligible non-zero: regs[wr_addr[w]] <= wr_data[w]; gnt <= onehot(w); ptr <= (w+1) mod NREQ; busy <= 1.
- Write edge, eligible zero: gnt <= 0; busy <= 0; ptr unchanged.
- clr_all high at an edge: all regs <= 0; gnt <= 0; busy <= 1; ptr unchanged.
  - No write occurs in that cycle. Pending requests stay pending and are arbitrated next cycle.
- Latency: req rising before edge k with no contention -> write and gnt both visible after edge k. rd_data reflects the new value in the cycle gnt is high.
- Fairness: with all NREQ requesting continuously, each is granted exactly once in any NREQ-grant window.
- Address collision, two requesters targeting the same register: writes are serialised by arbitration; the last granted writer's value persists.
- Reset mid-operation: an in-flight gnt is dropped immediately. Requesters must re-request; no write is lost or replayed by the arbiter.
- No internal FSM states beyond ptr and the gnt register; arbitration is single-cycle.

Decomposition:
- Shared package: DW, default NREQ/NREGS/AW constants, and a onehot-encode function.
- One natural sub-module: rr_pick (combinational round-robin winner select from eligible vector and ptr, outputs valid and index).
- The register bank stays inline as an array of DW-wide registers with async ClearN.

Test Plan:
- Reset: ClearN=0 mid-run with req=4'b1111 -> gnt=0, busy=0, rd_data=0 for every rd_addr; after release the first grant goes to requester 0.
- Single requester: req=4'b0100, wr_addr[2]=2'd3, wr_data[2]=32'hAFAFAFAF -> after 1 edge gnt=4'b0100 and rd_data@3=32'hAFAFAFAF. Requester drops req -> next cycle gnt=0.
- Full contention: req=4'b1111 held 8 cycles, each requester writing its own index to addr i -> gnt sequence 0001,0010,0100,1000,0001,… with no gaps and no repeats. After 4 grants, regs = {3,2,1,0}.
- Requester that ignores gnt and keeps req high alone: req=4'b0001 held -> gnt pattern 1,0,1,0. Writes occur only on gnt edges.
- Clear priority: regs preloaded 32'h12345678; clr_all with req=4'b0010 pending -> that edge gnt=0 and all regs=0; next edge gnt=4'b0010 and the write lands.
- Collision: req=4'b0011, both targeting addr 1 with 32'h11111111 and 32'h22222222, ptr=0 -> final rd_data@1=32'h22222222 after two grants.
